byteswap_engine: RTL and testbench

Runtime-configurable byte-swap stream engine. It is the next-generation replacement for the fixed 32-bit-word swapper that sits between the AXI read master and the AXI write master in the byteswap kernel.
- Swaps bytes within 16-, 32- or 64-bit lanes, or passes data through, selected per transfer.
- Counts beats against a byte length and generates m_tlast and a partial m_tkeep on the final beat.
- Reports per-transfer completion to the kernel control logic.
- Uses a 2-entry skid buffer for full throughput with registered ready.

---
 rtl/byteswap_engine_if.sv | 29 ++
 rtl/byteswap_engine.sv | 153 +++++++++++++++
 tb/tb_byteswap_engine.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/byteswap_engine_if.sv
// Control + AXI-stream bundle for byteswap_engine.
// slave = engine side, master = the block feeding/draining the engine.
interface byteswap_engine_if #(
    parameter int C_DATA_WIDTH   = 512,
    parameter int C_LENGTH_WIDTH = 32
);
    logic                        ctrl_start;
    logic [C_LENGTH_WIDTH-1:0]   ctrl_length;
    logic [1:0]                  ctrl_mode;
    logic                        ctrl_busy;
    logic                        ctrl_done;
    logic                        s_tvalid;
    logic                        s_tready;
    logic [C_DATA_WIDTH-1:0]     s_tdata;
    logic                        m_tvalid;
    logic                        m_tready;
    logic [C_DATA_WIDTH-1:0]     m_tdata;
    logic [C_DATA_WIDTH/8-1:0]   m_tkeep;
    logic                        m_tlast;

    modport slave (
        input  ctrl_start, ctrl_length, ctrl_mode, s_tvalid, s_tdata, m_tready,
        output ctrl_busy, ctrl_done, s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast
    );
    modport master (
        output ctrl_start, ctrl_length, ctrl_mode, s_tvalid, s_tdata, m_tready,
        input  ctrl_busy, ctrl_done, s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast
    );
endinterface

// File: rtl/byteswap_engine.sv
// Runtime-selectable byte-swap stream engine with a 2-entry skid buffer and length-driven tlast/tkeep.
// Optional BYTESWAP_ENGINE_STATS_EN adds stat_beats / stat_stall counters.
module byteswap_engine #(
    parameter int C_DATA_WIDTH     = 512,
    parameter int C_BYTE_BIT_WIDTH = 8,
    parameter int C_LENGTH_WIDTH   = 32
) (
    input  logic             ap_clk,
    input  logic             areset,
    byteswap_engine_if.slave bus
`ifdef BYTESWAP_ENGINE_STATS_EN
    ,
    output logic [31:0]      stat_beats,
    output logic [31:0]      stat_stall
`endif
);
    localparam int DWB     = C_DATA_WIDTH / 8;
    localparam int LOG_DWB = $clog2(DWB);
    localparam int BB      = C_BYTE_BIT_WIDTH;
    localparam int NBYTE   = C_DATA_WIDTH / BB;
    localparam int CW      = C_LENGTH_WIDTH + 1;
    localparam int M16     = 16 / BB - 1;
    localparam int M32     = 32 / BB - 1;
    localparam int M64     = 64 / BB - 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                        state_q, state_d;
    logic [1:0]                    mode_q;
    logic [LOG_DWB-1:0]            tail_q;
    logic [CW-1:0]                 rem_q, rem_d, beats;
    logic                          busy_q, done_q, s_rdy_q;
    logic [1:0][C_DATA_WIDTH-1:0]  dat_q;
    logic [1:0][DWB-1:0]           keep_q;
    logic [1:0]                    last_q, vld_q, vld_d;
    logic [C_DATA_WIDTH-1:0]       swp;
    logic [DWB-1:0]                keep_in;
    logic                          start_ok, push, pop, last_in;

    // Extra bit keeps the round-up from wrapping at the maximum length.
    assign beats = ({1'b0, bus.ctrl_length} + CW'(DWB - 1)) >> LOG_DWB;

    // Byte b of a lane takes byte (b XOR lane_mask), which mirrors it inside its lane.
    for (genvar b = 0; b < NBYTE; b++) begin : g_byte
        localparam int S16 = b ^ M16;
        localparam int S32 = b ^ M32;
        localparam int S64 = b ^ M64;
        assign swp[b*BB +: BB] = (mode_q == 2'd1) ? bus.s_tdata[S16*BB +: BB] :
                                 (mode_q == 2'd2) ? bus.s_tdata[S32*BB +: BB] :
                                 (mode_q == 2'd3) ? bus.s_tdata[S64*BB +: BB] :
                                                    bus.s_tdata[b*BB +: BB];
    end

    always_comb begin
        start_ok = (state_q == IDLE) && bus.ctrl_start;
        push     = bus.s_tvalid && s_rdy_q;
        pop      = vld_q[0] && bus.m_tready;
        last_in  = (rem_q == CW'(1));
        keep_in  = (last_in && tail_q != '0) ? ~({DWB{1'b1}} << tail_q) : {DWB{1'b1}};
        state_d  = state_q;
        rem_d    = rem_q;
        unique case (state_q)
            IDLE:  if (start_ok) begin
                       rem_d   = beats;
                       state_d = (beats == '0) ? DONE : RUN;
                   end
            RUN:   if (push) begin
                       rem_d = rem_q - CW'(1);
                       if (last_in) state_d = DRAIN;
                   end
            DRAIN: if (pop && last_q[0]) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        unique case ({push, pop})
            2'b10:   vld_d = vld_q[0] ? 2'b11 : 2'b01;
            2'b01:   vld_d = {1'b0, vld_q[1]};
            default: vld_d = vld_q;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state_q <= IDLE;
            mode_q  <= '0;
            tail_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_rdy_q <= 1'b0;
            dat_q   <= '0;
            keep_q  <= '0;
            last_q  <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            vld_q   <= vld_d;
            done_q  <= (state_q == DONE);
            // Ready looks one cycle ahead so a full buffer never sees a push.
            s_rdy_q <= (state_d == RUN) && (rem_d != '0) && !vld_d[1];
            if (start_ok) begin
                mode_q <= bus.ctrl_mode;
                tail_q <= bus.ctrl_length[LOG_DWB-1:0];
                busy_q <= 1'b1;
            end else if (state_q == DONE) begin
                busy_q <= 1'b0;
            end
            if (pop) begin
                dat_q[0]  <= dat_q[1];
                keep_q[0] <= keep_q[1];
                last_q[0] <= last_q[1];
            end
            if (push) begin
                if (vld_d[1]) begin
                    dat_q[1]  <= swp;
                    keep_q[1] <= keep_in;
                    last_q[1] <= last_in;
                end else begin
                    dat_q[0]  <= swp;
                    keep_q[0] <= keep_in;
                    last_q[0] <= last_in;
                end
            end
        end
    end

    assign bus.ctrl_busy = busy_q;
    assign bus.ctrl_done = done_q;
    assign bus.s_tready  = s_rdy_q;
    assign bus.m_tvalid  = vld_q[0];
    assign bus.m_tdata   = dat_q[0];
    assign bus.m_tkeep   = keep_q[0];
    assign bus.m_tlast   = last_q[0];

`ifdef BYTESWAP_ENGINE_STATS_EN
    logic [31:0] sbeats_q, sstall_q;

    always_ff @(posedge ap_clk) begin
        if (areset || start_ok) begin
            sbeats_q <= '0;
            sstall_q <= '0;
        end else begin
            if (pop && sbeats_q != '1) sbeats_q <= sbeats_q + 32'd1;
            if ((state_q == RUN || state_q == DRAIN) && vld_q[0] && !bus.m_tready && sstall_q != '1)
                sstall_q <= sstall_q + 32'd1;
        end
    end

    assign stat_beats = sbeats_q;
    assign stat_stall = sstall_q;
`endif
endmodule

// File: tb/tb_byteswap_engine.sv
// Directed + randomized checks of byteswap_engine against a byte-array reference model.
module tb_byteswap_engine;
    localparam int DW  = 512;
    localparam int LW  = 32;
    localparam int DWB = DW / 8;

    logic ap_clk = 1'b0;
    logic areset;
    always #5 ap_clk = ~ap_clk;

    byteswap_engine_if #(.C_DATA_WIDTH(DW), .C_LENGTH_WIDTH(LW)) bus ();
`ifdef BYTESWAP_ENGINE_STATS_EN
    logic [31:0] stat_beats, stat_stall;
`endif

    byteswap_engine #(.C_DATA_WIDTH(DW), .C_BYTE_BIT_WIDTH(8), .C_LENGTH_WIDTH(LW)) dut (
        .ap_clk (ap_clk),
        .areset (areset),
        .bus    (bus)
`ifdef BYTESWAP_ENGINE_STATS_EN
        ,
        .stat_beats (stat_beats),
        .stat_stall (stat_stall)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0]  first_beat;
    logic [DWB-1:0] last_keep;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lane of L bytes (L = 1,2,4,8): output byte k takes the mirrored byte of its lane.
    function automatic logic [DW-1:0] ref_swap(input logic [DW-1:0] d, input logic [1:0] mode);
        logic [DW-1:0] r;
        int L;
        L = 1 << mode;
        for (int k = 0; k < DWB; k++)
            r[k*8 +: 8] = d[((k / L) * L + (L - 1 - k % L)) * 8 +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] beat_data(input int pat);
        logic [DW-1:0] r;
        for (int w = 0; w < DW / 32; w++) begin
            case (pat)
                1:       r[w*32 +: 32] = 32'h11223344;
                2:       r[w*32 +: 32] = 32'hAABBAABB;
                default: r[w*32 +: 32] = $urandom;
            endcase
        end
        return r;
    endfunction

    // rdy: 0 always ready, 1 toggling, 2 random. mid: pulse a conflicting start mid-transfer.
    task automatic run_xfer(input logic [1:0] mode, input int len, input int rdy, input int pat, input bit mid);
        logic [DW-1:0]  src[$];
        logic [DW-1:0]  hd;
        logic [DWB-1:0] hk, kexp;
        logic           hv, hl;
        int nb, tail, sent, got, dones, stalls, cyc, done_cyc, fpush, fvld;
        nb = (len + DWB - 1) / DWB;
        tail = len % DWB;
        sent = 0; got = 0; dones = 0; stalls = 0; cyc = 0; done_cyc = -1; fpush = -1; fvld = -1;
        hv = 1'b0; hd = '0; hk = '0; hl = 1'b0;
        for (int i = 0; i < nb; i++) src.push_back(beat_data(pat));
        @(negedge ap_clk);
        bus.ctrl_start = 1'b1; bus.ctrl_length = len; bus.ctrl_mode = mode;
        bus.s_tvalid = 1'b0; bus.m_tready = 1'b0;
        @(negedge ap_clk);
        bus.ctrl_start = 1'b0;
        chk("busy_after_start", bus.ctrl_busy, 1);
        while (cyc < 3000 && (done_cyc < 0 || cyc < done_cyc + 4)) begin
            if (bus.ctrl_done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
                chk("busy_low_at_done", bus.ctrl_busy, 0);
                chk("done_after_all_beats", got, nb);
            end
            if (hv) begin
                chk("stall_valid", bus.m_tvalid, 1);
                chk("stall_data", bus.m_tdata, hd);
                chk("stall_keep", bus.m_tkeep, hk);
                chk("stall_last", bus.m_tlast, hl);
            end
            if (bus.m_tvalid && fvld < 0) fvld = cyc;
            bus.ctrl_start = mid && (cyc == 2);
            if (mid && cyc == 2) begin bus.ctrl_mode = 2'b00; bus.ctrl_length = 64; end
            bus.s_tvalid = (pat != 0) || ($urandom_range(0, 3) != 0);
            bus.s_tdata  = (sent < nb) ? src[sent] : beat_data(0);
            case (rdy)
                0:       bus.m_tready = 1'b1;
                1:       bus.m_tready = cyc[0];
                default: bus.m_tready = ($urandom_range(0, 2) != 0);
            endcase
            if (bus.s_tvalid && bus.s_tready) begin
                if (fpush < 0) fpush = cyc;
                sent++;
            end
            if (bus.m_tvalid && bus.m_tready) begin
                if (got < nb) begin
                    kexp = (got == nb - 1 && tail != 0) ? ~({DWB{1'b1}} << tail) : {DWB{1'b1}};
                    chk("beat_data", bus.m_tdata, ref_swap(src[got], mode));
                    chk("beat_keep", bus.m_tkeep, kexp);
                    chk("beat_last", bus.m_tlast, got == nb - 1);
                    if (got == 0) first_beat = bus.m_tdata;
                    if (got == nb - 1) last_keep = bus.m_tkeep;
                end else begin
                    chk("extra_output_beat", 1, 0);
                end
                got++;
            end
            hv = bus.m_tvalid && !bus.m_tready;
            hd = bus.m_tdata; hk = bus.m_tkeep; hl = bus.m_tlast;
            if (hv) stalls++;
            cyc++;
            @(negedge ap_clk);
        end
        bus.s_tvalid = 1'b0; bus.m_tready = 1'b0; bus.ctrl_start = 1'b0;
        chk("done_count", dones, 1);
        chk("in_beats_consumed", sent, nb);
        chk("out_beats", got, nb);
        chk("first_beat_latency", fvld - fpush, 1);
`ifdef BYTESWAP_ENGINE_STATS_EN
        chk("stat_beats", stat_beats, nb);
        chk("stat_stall", stat_stall, stalls);
`endif
    endtask

    initial begin
        int n, dn;
        areset = 1'b1;
        bus.ctrl_start = 1'b0; bus.ctrl_length = '0; bus.ctrl_mode = '0;
        bus.s_tvalid = 1'b0; bus.s_tdata = '0; bus.m_tready = 1'b0;
        repeat (3) @(negedge ap_clk);
        areset = 1'b0;
        @(negedge ap_clk);
        chk("rst_s_tready", bus.s_tready, 0);
        chk("rst_m_tvalid", bus.m_tvalid, 0);
        chk("rst_m_tdata", bus.m_tdata, 0);
        chk("rst_m_tkeep", bus.m_tkeep, 0);
        chk("rst_m_tlast", bus.m_tlast, 0);
        chk("rst_busy", bus.ctrl_busy, 0);
        chk("rst_done", bus.ctrl_done, 0);
`ifdef BYTESWAP_ENGINE_STATS_EN
        chk("rst_stat_beats", stat_beats, 0);
        chk("rst_stat_stall", stat_stall, 0);
`endif

        // swap32 of a fixed word, full beats
        run_xfer(2'b10, 128, 0, 1, 0);
        chk("swap32_word", first_beat, {16{32'h44332211}});
        chk("swap32_keep", last_keep, {DWB{1'b1}});

        // swap16, partial final beat of 36 bytes
        run_xfer(2'b01, 100, 0, 2, 0);
        chk("swap16_word", first_beat, {32{16'hBBAA}});
        chk("swap16_tail_keep", last_keep, 64'h0000000FFFFFFFFF);

        // swap64 with m_tready toggling
        run_xfer(2'b11, 256, 1, 0, 0);

        // zero length: done two cycles after start, no stream activity
        @(negedge ap_clk);
        bus.ctrl_start = 1'b1; bus.ctrl_length = 0; bus.ctrl_mode = 2'b10;
        bus.s_tvalid = 1'b1; bus.m_tready = 1'b1;
        @(negedge ap_clk);
        bus.ctrl_start = 1'b0;
        chk("len0_c1_done", bus.ctrl_done, 0);
        chk("len0_c1_busy", bus.ctrl_busy, 1);
        chk("len0_c1_sready", bus.s_tready, 0);
        chk("len0_c1_mvalid", bus.m_tvalid, 0);
        @(negedge ap_clk);
        chk("len0_c2_done", bus.ctrl_done, 1);
        chk("len0_c2_busy", bus.ctrl_busy, 0);
        chk("len0_c2_sready", bus.s_tready, 0);
        chk("len0_c2_mvalid", bus.m_tvalid, 0);
        @(negedge ap_clk);
        chk("len0_c3_done", bus.ctrl_done, 0);
        bus.s_tvalid = 1'b0; bus.m_tready = 1'b0;

        // conflicting start mid-transfer is ignored
        run_xfer(2'b11, 320, 2, 0, 1);

        // reset after the first output beat of a 4-beat transfer
        @(negedge ap_clk);
        bus.ctrl_start = 1'b1; bus.ctrl_length = 256; bus.ctrl_mode = 2'b11;
        bus.s_tvalid = 1'b1; bus.s_tdata = beat_data(0); bus.m_tready = 1'b1;
        @(negedge ap_clk);
        bus.ctrl_start = 1'b0;
        n = 0;
        while (!(bus.m_tvalid && bus.m_tready) && n < 50) begin @(negedge ap_clk); n++; end
        chk("abort_beat1_seen", n < 50, 1);
        @(negedge ap_clk);
        areset = 1'b1; bus.s_tvalid = 1'b0;
        @(negedge ap_clk);
        areset = 1'b0;
        chk("abort_mvalid", bus.m_tvalid, 0);
        chk("abort_busy", bus.ctrl_busy, 0);
        chk("abort_sready", bus.s_tready, 0);
        dn = 0;
        repeat (8) begin @(negedge ap_clk); if (bus.ctrl_done) dn++; end
        chk("abort_no_done", dn, 0);
        run_xfer(2'b10, 64, 0, 0, 0);

        // boundaries and randomized transfers
        run_xfer(2'b01, 1, 2, 0, 0);
        run_xfer(2'b00, 65, 2, 0, 0);
        for (int t = 0; t < 6; t++)
            run_xfer(2'($urandom_range(0, 3)), $urandom_range(1, 700), $urandom_range(0, 2), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
